// File: rtl/vector_frame_buffer.sv
// vector_frame_buffer: double-buffered store for vector display words.
// The producer fills the write bank while the display side reads the other bank.
// A complete frame waits in PENDING until the display's frame_sync pulse, and the
// bank swap happens on that pulse.
// Optional macro VFB_CLEAR_EN: after reset, zero both banks before accepting writes.
module vector_frame_buffer #(
  parameter int ADDRESSWIDTH = 8,
  parameter int DATAWIDTH    = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATAWIDTH-1:0]    wr_data,
  input  logic                    wr_last,
  input  logic                    frame_sync,
  input  logic [ADDRESSWIDTH-1:0] rd_addr,
  output logic [DATAWIDTH-1:0]    rd_data,
  output logic                    disp_bank,
  output logic                    frame_pending,
  output logic                    overflow
);
  localparam int DEPTH = 1 << ADDRESSWIDTH;
  localparam logic [ADDRESSWIDTH-1:0] PTR_MAX = {ADDRESSWIDTH{1'b1}};

  typedef enum logic [1:0] {CLEAR = 2'd0, WRITE = 2'd1, PENDING = 2'd2} state_t;

  state_t                  state;
  logic [ADDRESSWIDTH-1:0] wr_ptr;
  logic [DATAWIDTH-1:0]    mem [0:2*DEPTH-1];

  logic                    accept;
  logic                    last_word;
  logic                    swap;
  logic                    rd_bank;
  logic                    mem_we;
  logic [ADDRESSWIDTH:0]   mem_waddr;
  logic [DATAWIDTH-1:0]    mem_wdata;

  // Status outputs decode straight from the state register.
  assign wr_ready      = (state == WRITE);
  assign frame_pending = (state == PENDING);
  assign accept        = wr_valid && wr_ready;
  // A word at the last bank slot ends the frame whether or not wr_last is set.
  assign last_word     = wr_last || (wr_ptr == PTR_MAX);
  assign swap          = frame_pending && frame_sync;
  // Reads on the swap edge already come from the new display bank.
  assign rd_bank       = swap ? ~disp_bank : disp_bank;

`ifdef VFB_CLEAR_EN
  logic [ADDRESSWIDTH:0] clr_cnt;

  // Write port mux: clear sweep over both banks, otherwise producer into write bank.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = {~disp_bank, wr_ptr};
    mem_wdata = wr_data;
    if (rst) begin
      if (state == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt;
        mem_wdata = '0;
      end else begin
        mem_we    = accept;
      end
    end
  end
`else
  // Write port: producer words only ever land in the non-displayed bank.
  always_comb begin
    mem_we    = rst && accept;
    mem_waddr = {~disp_bank, wr_ptr};
    mem_wdata = wr_data;
  end
`endif

  // Bank storage, both banks in one array indexed {bank, word}.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Registered display read; forced to zero during reset and clearing.
  always_ff @(posedge clk) begin
    if (!rst)                  rd_data <= '0;
    else if (state == CLEAR)   rd_data <= '0;
    else                       rd_data <= mem[{rd_bank, rd_addr}];
  end

  // Frame control FSM: fill write bank, hold complete frame, swap on frame_sync.
  always_ff @(posedge clk) begin
    if (!rst) begin
      disp_bank <= 1'b0;
      wr_ptr    <= '0;
      overflow  <= 1'b0;
`ifdef VFB_CLEAR_EN
      state     <= CLEAR;
      clr_cnt   <= '0;
`else
      state     <= WRITE;
`endif
    end else begin
      case (state)
`ifdef VFB_CLEAR_EN
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == {(ADDRESSWIDTH+1){1'b1}}) state <= WRITE;
        end
`endif
        WRITE: begin
          if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (last_word) state <= PENDING;
            if (!wr_last && wr_ptr == PTR_MAX) overflow <= 1'b1;
          end
        end
        PENDING: begin
          if (frame_sync) begin
            disp_bank <= ~disp_bank;
            wr_ptr    <= '0;
            state     <= WRITE;
          end
        end
        default: state <= WRITE;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_frame_buffer.sv
// tb_vector_frame_buffer: scoreboard bench for vector_frame_buffer.
// The driver advances a frame-level reference model each cycle and queues the
// expected post-edge outputs; a negedge monitor pops and compares them.
module tb_vector_frame_buffer;
  localparam int AW    = 8;
  localparam int DW    = 18;
  localparam int DEPTH = 1 << AW;
`ifdef VFB_CLEAR_EN
  localparam int CLR_CYC = 2 * DEPTH;
`else
  localparam int CLR_CYC = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          wr_last = 1'b0;
  logic          frame_sync = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          disp_bank;
  logic          frame_pending;
  logic          overflow;

  vector_frame_buffer #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_last(wr_last), .frame_sync(frame_sync),
    .rd_addr(rd_addr), .rd_data(rd_data), .disp_bank(disp_bank),
    .frame_pending(frame_pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rdy;
    logic          pend;
    logic          ovf;
    logic          disp;
    logic [DW-1:0] rd;
    logic          rdk;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: two banks of words, which one is shown, and frame progress.
  logic [DW-1:0] bank  [2][DEPTH];
  bit            known [2][DEPTH];
  bit            m_disp, m_pend, m_ovf;
  int            m_fill;
  int            m_clr;
  logic [DW-1:0] m_rd;
  bit            m_rdk;

  task automatic model_edge();
    bit nd;
    if (!rst) begin
      m_disp = 0; m_pend = 0; m_ovf = 0; m_fill = 0;
      m_rd = '0; m_rdk = 1; m_clr = CLR_CYC;
      for (int b = 0; b < 2; b++)
        for (int w = 0; w < DEPTH; w++) known[b][w] = 0;
    end else if (m_clr > 0) begin
      m_rd = '0; m_rdk = 1;
      m_clr--;
      if (m_clr == 0)
        for (int b = 0; b < 2; b++)
          for (int w = 0; w < DEPTH; w++) begin bank[b][w] = '0; known[b][w] = 1; end
    end else begin
      nd = (m_pend && frame_sync) ? !m_disp : m_disp;
      m_rd  = bank[nd][rd_addr];
      m_rdk = known[nd][rd_addr];
      if (!m_pend && wr_valid) begin
        bank[!m_disp][m_fill]  = wr_data;
        known[!m_disp][m_fill] = 1;
        if (m_fill == DEPTH - 1 && !wr_last) m_ovf = 1;
        if (wr_last || m_fill == DEPTH - 1) m_pend = 1;
        m_fill++;
      end else if (m_pend && frame_sync) begin
        m_pend = 0; m_fill = 0; m_disp = nd;
      end
    end
  endtask

  task automatic step();
    exp_t e;
    model_edge();
    e.rdy = (m_clr == 0) && !m_pend;
    e.pend = m_pend; e.ovf = m_ovf; e.disp = m_disp;
    e.rd = m_rd; e.rdk = m_rdk;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic v, input logic l, input logic fs,
                       input logic [DW-1:0] d, input logic [AW-1:0] a);
    rst = r; wr_valid = v; wr_last = l; frame_sync = fs; wr_data = d; rd_addr = a;
    step();
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, '0, '0);
    while (m_clr > 0) drive(1, 0, 0, 0, '0, AW'($urandom));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("wr_ready", 32'(wr_ready), 32'(e.rdy));
      chk("frame_pending", 32'(frame_pending), 32'(e.pend));
      chk("overflow", 32'(overflow), 32'(e.ovf));
      chk("disp_bank", 32'(disp_bank), 32'(e.disp));
      if (e.rdk) chk("rd_data", 32'(rd_data), 32'(e.rd));
    end
  end

  initial begin
    logic v, l, fs, r;
    do_reset();

    // Three-word frame, swap, then read word 1 from the new display bank.
    drive(1, 1, 0, 0, 18'h00401, '0);
    drive(1, 1, 0, 0, 18'h00803, '0);
    drive(1, 1, 1, 0, 18'h00C03, '0);
    drive(1, 0, 0, 1, '0, '0);
    drive(1, 0, 0, 0, '0, 8'd1);
    drive(1, 0, 0, 0, '0, 8'd2);

    // frame_sync while mid-frame is ignored.
    drive(1, 1, 0, 1, 18'h11111, 8'd0);
    drive(1, 0, 0, 1, '0, 8'd1);
    drive(1, 1, 0, 1, 18'h22222, 8'd2);
    // frame_sync coincident with wr_last accept: swap deferred.
    drive(1, 1, 1, 1, 18'h33333, 8'd0);
    drive(1, 0, 0, 0, '0, 8'd0);
    drive(1, 0, 0, 1, '0, 8'd2);
    drive(1, 0, 0, 0, '0, 8'd1);

    // Overflow: full bank without wr_last.
    do_reset();
    for (int i = 0; i < DEPTH; i++) drive(1, 1, 0, 0, DW'($urandom), AW'(i));
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, DW'($urandom), AW'(DEPTH - 1 - i));
    drive(1, 0, 0, 1, '0, 8'hFF);
    drive(1, 0, 0, 0, '0, 8'h80);

    // Reset while a frame is pending.
    drive(1, 1, 0, 0, 18'h0ABCD, 8'd0);
    drive(1, 1, 1, 0, 18'h01234, 8'd0);
    drive(1, 0, 0, 0, '0, 8'd0);
    do_reset();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 799) != 0);
      v  = ($urandom_range(0, 9) < 7);
      l  = ($urandom_range(0, 19) == 0);
      fs = ($urandom_range(0, 9) == 0);
      drive(r, v, l, fs, DW'($urandom),
            ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15)));
      while (m_clr > 0) drive(1, 0, 0, 0, '0, AW'($urandom));
    end

    drive(1, 0, 0, 0, '0, '0);
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/vector_frame_buffer.md
VECTOR_FRAME_BUFFER -- requirements
Module: vector_frame_buffer

Interface
REQ-001 SHALL have parameter ADDRESSWIDTH, default 8, meaning the word address width of each bank (2^ADDRESSWIDTH words per bank).
REQ-002 SHALL have parameter DATAWIDTH, default 18, meaning the vector word width {y[17:10], x[9:2], line[1], pos[0]}.
REQ-003 SHALL have port clk  input  1  the single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port wr_valid  input  1  producer offers wr_data.
REQ-006 SHALL have port wr_ready  output  1  block accepts a word this cycle.
REQ-007 SHALL have port wr_data  input  DATAWIDTH  vector word to store.
REQ-008 SHALL have port wr_last  input  1  qualifies wr_data as the final word of a frame.
REQ-009 SHALL have port frame_sync  input  1  one-cycle pulse from the display side marking the end of a display frame.
REQ-010 SHALL have port rd_addr  input  ADDRESSWIDTH  display-side read address.
REQ-011 SHALL have port rd_data  output  DATAWIDTH  registered read data from the display bank.
REQ-012 SHALL have port disp_bank  output  1  index of the bank currently being displayed.
REQ-013 SHALL have port frame_pending  output  1  a complete frame is waiting for swap.
REQ-014 SHALL have port overflow  output  1  sticky flag: a frame exceeded bank capacity.

Function
REQ-015 SHALL hold two banks: the display bank (disp_bank) and the write bank (~disp_bank).
REQ-016 SHALL transfer a word when wr_valid and wr_ready are both high on a rising clk edge, and write it to the write bank at wr_ptr, then increment wr_ptr.
REQ-017 SHALL implement states CLEAR, WRITE and PENDING; wr_ready SHALL be high only in WRITE.
REQ-018 SHALL go WRITE -> PENDING on an accepted word with wr_last=1; frame_pending SHALL be high exactly in PENDING.
REQ-019 SHALL, on an accepted word at wr_ptr = 2^ADDRESSWIDTH-1 with wr_last=0, store it, treat it as the last word (go to PENDING), and set overflow.
REQ-020 SHALL hold overflow high until reset.
REQ-021 SHALL, on frame_sync in PENDING, toggle disp_bank, clear wr_ptr to 0 and return to WRITE in the next cycle.
REQ-022 SHALL ignore frame_sync in WRITE or CLEAR, so the display bank repeats unchanged.
REQ-023 SHALL not swap when frame_sync coincides with the accepting edge of wr_last; that swap SHALL occur on the next frame_sync.
REQ-024 SHALL provide rd_data = display bank[rd_addr] one cycle after rd_addr is presented (1-cycle latency, registered).
REQ-025 SHALL update rd_data on the cycle a swap takes effect with data from the new display bank, with no mixing of banks within one read.
REQ-026 SHALL not allow a write to modify the display bank under any input sequence.

Reset
REQ-027 SHALL, with rst=0 on a rising edge, set disp_bank=0, wr_ptr=0, overflow=0, frame_pending=0 and rd_data=0, and enter CLEAR if VFB_CLEAR_EN is defined, else WRITE.
REQ-028 SHALL, on reset during WRITE or PENDING, discard the partial or pending frame with no swap.

Configuration
REQ-029 SHALL, with macro VFB_CLEAR_EN defined, spend 2*2^ADDRESSWIDTH cycles in CLEAR after reset writing zero to every word of both banks, with wr_ready=0 and rd_data=0, then enter WRITE.
REQ-030 SHALL, without VFB_CLEAR_EN, enter WRITE immediately after reset, with bank contents undefined until first written.

Verification
REQ-031 SHALL cover: 3 words 0x00401, 0x00803, 0x00C03 written (last on third), frame_sync -> disp_bank=1, rd_addr=1 gives rd_data=0x00803 one cycle later.
REQ-032 SHALL cover: frame_sync pulses while in WRITE mid-frame -> disp_bank unchanged, frame_pending=0, wr_ready stays 1.
REQ-033 SHALL cover: 256 words written with wr_last=0 -> 256th accepted, overflow=1, frame_pending=1, wr_ready=0, and overflow still 1 after the next swap.
REQ-034 SHALL cover: frame_sync coincident with the wr_last accept -> no swap that cycle, swap on the following frame_sync.
REQ-035 SHALL cover: with VFB_CLEAR_EN, after reset release wr_ready=0 for 512 cycles, then 1, and any rd_addr reads 0.
REQ-036 SHALL cover: rst=0 asserted in PENDING -> disp_bank=0, frame_pending=0, overflow=0 on the next edge.
